// File: rtl/rng_health_monitor.sv
// Online health monitor for a 32-bit RNG word stream: repetition-count test
// plus windowed monobit test, with latched alarm and per-window reporting.
module rng_health_monitor #(
   parameter logic [15:0] WINDOW_WORDS = 16'd64,
   parameter logic [7:0]  REP_LIMIT    = 8'd4,
   parameter logic [15:0] ONES_MIN     = 16'd944,
   parameter logic [15:0] ONES_MAX     = 16'd1104
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        clear,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] ones_count,
   output logic [15:0] win_count,
   output logic        rep_fail,
   output logic        mono_fail,
   output logic        alarm
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;
   localparam int unsigned RW = 8;
   localparam int unsigned PW = 6;

   typedef enum logic [1:0] {IDLE, RUN, CHECK, FAIL} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   ones_acc, ones_acc_nxt;
   logic [CW-1:0]   word_cnt, word_cnt_nxt;
   logic [RW-1:0]   rep_cnt, rep_cnt_nxt;
   logic [DW-1:0]   prev_word, prev_word_nxt;
   logic            prev_vld, prev_vld_nxt;
   logic [CW-1:0]   ones_count_nxt, win_count_nxt;
   logic            done_nxt, pass_nxt, rep_fail_nxt, mono_fail_nxt;
   logic            in_ready_nxt, busy_nxt, alarm_nxt;

   logic [PW-1:0]   pop_c;
   logic            accept_c;
   logic [CW-1:0]   acc_upd_c;
   logic [RW-1:0]   rep_upd_c;
   logic            win_pass_c;

   // Popcount of the incoming word
   always_comb begin
      pop_c = '0;
      for (int i = 0; i < DW; i++) begin
         pop_c = pop_c + PW'(in_data[i]);
      end
   end

   assign accept_c   = in_valid && (state == RUN);
   assign acc_upd_c  = ones_acc + CW'(pop_c);
   assign rep_upd_c  = (prev_vld && (in_data == prev_word)) ? rep_cnt + RW'(1) : RW'(1);
   assign win_pass_c = (acc_upd_c >= ONES_MIN) && (acc_upd_c <= ONES_MAX);

   // Next-state and next-output logic; window results are produced on the
   // last accept so they are visible during the CHECK cycle.
   always_comb begin
      state_nxt      = state;
      ones_acc_nxt   = ones_acc;
      word_cnt_nxt   = word_cnt;
      rep_cnt_nxt    = rep_cnt;
      prev_word_nxt  = prev_word;
      prev_vld_nxt   = prev_vld;
      ones_count_nxt = ones_count;
      win_count_nxt  = win_count;
      done_nxt       = 1'b0;
      pass_nxt       = pass;
      rep_fail_nxt   = rep_fail;
      mono_fail_nxt  = mono_fail;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt    = RUN;
               ones_acc_nxt = '0;
               word_cnt_nxt = '0;
               rep_cnt_nxt  = '0;
               prev_vld_nxt = 1'b0;
            end
         end
         RUN: begin
            if (accept_c) begin
               ones_acc_nxt  = acc_upd_c;
               rep_cnt_nxt   = rep_upd_c;
               prev_word_nxt = in_data;
               prev_vld_nxt  = 1'b1;
               if (rep_upd_c == REP_LIMIT) begin
                  state_nxt    = FAIL;
                  rep_fail_nxt = 1'b1;
               end else if (word_cnt == WINDOW_WORDS - 16'd1) begin
                  state_nxt      = CHECK;
                  done_nxt       = 1'b1;
                  pass_nxt       = win_pass_c;
                  ones_count_nxt = acc_upd_c;
                  ones_acc_nxt   = '0;
                  word_cnt_nxt   = '0;
                  if (win_pass_c) begin
                     if (win_count != 16'hFFFF) win_count_nxt = win_count + 16'd1;
                  end else begin
                     mono_fail_nxt = 1'b1;
                  end
               end else begin
                  word_cnt_nxt = word_cnt + 16'd1;
               end
            end
         end
         CHECK:   state_nxt = pass ? RUN : FAIL;
         FAIL:    state_nxt = FAIL;
         default: state_nxt = IDLE;
      endcase

      if (clear) begin
         state_nxt      = IDLE;
         ones_count_nxt = ones_count;
         win_count_nxt  = '0;
         done_nxt       = 1'b0;
         pass_nxt       = 1'b0;
         rep_fail_nxt   = 1'b0;
         mono_fail_nxt  = 1'b0;
      end

      in_ready_nxt = (state_nxt == RUN);
      busy_nxt     = (state_nxt != IDLE);
      alarm_nxt    = rep_fail_nxt | mono_fail_nxt;
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ones_acc   <= '0;
         word_cnt   <= '0;
         rep_cnt    <= '0;
         prev_word  <= '0;
         prev_vld   <= 1'b0;
         ones_count <= '0;
         win_count  <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         rep_fail   <= 1'b0;
         mono_fail  <= 1'b0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         alarm      <= 1'b0;
      end else begin
         state      <= state_nxt;
         ones_acc   <= ones_acc_nxt;
         word_cnt   <= word_cnt_nxt;
         rep_cnt    <= rep_cnt_nxt;
         prev_word  <= prev_word_nxt;
         prev_vld   <= prev_vld_nxt;
         ones_count <= ones_count_nxt;
         win_count  <= win_count_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         rep_fail   <= rep_fail_nxt;
         mono_fail  <= mono_fail_nxt;
         in_ready   <= in_ready_nxt;
         busy       <= busy_nxt;
         alarm      <= alarm_nxt;
      end
   end

endmodule
